matrix_act_stream: RTL and testbench
====================================

MATRIX_ACT_STREAM -- requirements
Module: matrix_act_stream

Interface
REQ-001 SHALL have parameter H, default 8, matrix row count.
REQ-002 SHALL have parameter W, default 8, matrix column count.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, signed fixed-point element width.
REQ-004 SHALL have parameter FRACT_WIDTH, default 8, fractional bits; legal range 6..DATA_WIDTH-3.
REQ-005 SHALL have parameter LANES, default 4, elements evaluated per cycle; legal range 1..H*W.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, input matrix offered.
REQ-009 SHALL have port in_ready, output, 1, block can accept a matrix.
REQ-010 SHALL have port mode, input, 1, 0 = tanh, 1 = sigmoid; sampled on acceptance.
REQ-011 SHALL have port a, input, H*W*DATA_WIDTH, element (i,j) at bits [(i*W+j)*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port out_valid, output, 1, result matrix valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port y, output, H*W*DATA_WIDTH, result matrix, same packing as a.
REQ-015 SHALL have port busy, output, 1, high in RUN.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 in_ready SHALL be high only in IDLE; in_valid&&in_ready SHALL capture a and mode into an internal buffer, clear the element counter, and enter RUN.
REQ-018 RUN SHALL evaluate elements idx..idx+LANES-1 each cycle, write them into y, advance idx by LANES.
REQ-019 Final group SHALL write only indices < H*W when H*W is not a multiple of LANES; other y bits untouched.
REQ-020 RUN SHALL last exactly ceil(H*W/LANES) cycles; out_valid SHALL rise on the edge processing the last group.
REQ-021 DONE SHALL hold out_valid and y stable until out_ready is high; then out_valid SHALL fall and FSM SHALL enter IDLE next edge. y SHALL retain its value in IDLE.
REQ-022 in_valid in RUN/DONE SHALL be ignored (not accepted); a changing during RUN SHALL not affect the result.
REQ-023 tanh on x: s = sign, m = |x| (most negative value saturates to max positive); f = m if m<0.5; m/2+0.25 if 0.5<=m<1.25; m/16+0.796875 if 1.25<=m<2.5; 1.0 if m>=2.5; shifts truncate; result = s ? -f : f.
REQ-024 sigmoid on x: t = tanh(x>>>1) per REQ-023; result = (t + 1.0)>>>1.
REQ-025 Constants SHALL be expressed in FRACT_WIDTH fixed point (0.25 = 1<<(FRACT_WIDTH-2), 0.796875 = 51<<(FRACT_WIDTH-6)).

Reset
REQ-026 rst SHALL force IDLE, in_ready=1, out_valid=0, busy=0, y=0, idx=0, captured mode=0, from any state.
REQ-027 rst mid-RUN or in DONE SHALL discard the pending matrix; no out_valid follows.

Configuration
REQ-028 Macro MATRIX_ACT_SIGMOID_EN defined: mode SHALL select per REQ-010/REQ-024.
REQ-029 MATRIX_ACT_SIGMOID_EN undefined: sigmoid logic SHALL be absent, mode ignored, all elements computed with tanh.

Verification (DATA_WIDTH=16, FRACT_WIDTH=8)
REQ-030 tanh values: 0x0040 -> 0x0040; 0x00C0 -> 0x00A0; 0xFF40 -> 0xFF60; 0x0200 -> 0x00EC; 0x0300 -> 0x0100; 0x8000 -> 0xFF00.
REQ-031 H=W=3, LANES=4, accept at edge k -> busy high edges k+1..k+3, out_valid rises at edge k+3, elements 0..8 correct, padding ignored.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 With MATRIX_ACT_SIGMOID_EN, mode=1, x=0x0000 -> 0x0080; x=0x0400 -> 0x00F6; without macro same stimulus -> tanh results 0x0000, 0x0100.
REQ-034 Assert rst two cycles after acceptance -> out_valid never rises, y=0, in_ready=1 next edge; new matrix then processes normally.
REQ-035 in_valid held high through RUN with changing a -> only the first matrix processed, result unaffected.

Source files
------------

// File: rtl/matrix_act_stream.sv
// ---------------------------------------------------------------------------
// matrix_act_stream
//
// Applies an element-wise activation (piecewise-linear tanh, or sigmoid built
// on the same tanh) to an H x W matrix of signed fixed-point values. A matrix
// is captured on an in_valid/in_ready handshake and processed LANES elements
// per cycle. The result is held on y with out_valid until out_ready is seen.
//
// Optional feature macro: MATRIX_ACT_SIGMOID_EN
//   defined   -> mode selects tanh (0) or sigmoid (1) per matrix
//   undefined -> no sigmoid hardware, mode is ignored, every element is tanh
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input matrix offered
//   in_ready   out  block can accept a matrix (IDLE only)
//   mode       in   0 = tanh, 1 = sigmoid, sampled on acceptance
//   a          in   H*W*DATA_WIDTH, element (i,j) at [(i*W+j)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  result matrix valid
//   out_ready  in   consumer accepts result
//   y          out  result matrix, same packing as a
//   busy       out  high while elements are being evaluated
// ---------------------------------------------------------------------------
module matrix_act_stream #(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic [H*W*DATA_WIDTH-1:0] a,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [H*W*DATA_WIDTH-1:0] y,
    output logic                      busy
);

    localparam int N     = H * W;
    localparam int IDX_W = $clog2(N + LANES) + 1;

    // Fixed-point constants in FRACT_WIDTH format.
    localparam logic signed [DATA_WIDTH-1:0] C_QUARTER = DATA_WIDTH'(1)  << (FRACT_WIDTH - 2);
    localparam logic signed [DATA_WIDTH-1:0] C_HALF    = DATA_WIDTH'(1)  << (FRACT_WIDTH - 1);
    localparam logic signed [DATA_WIDTH-1:0] C_ONE     = DATA_WIDTH'(1)  << FRACT_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] C_1P25    = DATA_WIDTH'(5)  << (FRACT_WIDTH - 2);
    localparam logic signed [DATA_WIDTH-1:0] C_2P5     = DATA_WIDTH'(5)  << (FRACT_WIDTH - 1);
    localparam logic signed [DATA_WIDTH-1:0] C_0P797   = DATA_WIDTH'(51) << (FRACT_WIDTH - 6);
    localparam logic signed [DATA_WIDTH-1:0] C_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] C_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [N*DATA_WIDTH-1:0] y_q, y_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;

    // Piecewise-linear tanh; the most negative input saturates to max positive
    // magnitude before the sign is reapplied.
    function automatic logic signed [DATA_WIDTH-1:0] tanh_pw(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] m;
        logic signed [DATA_WIDTH-1:0] f;
        if (x == C_MIN)
            m = C_MAX;
        else if (x < 0)
            m = -x;
        else
            m = x;
        if (m < C_HALF)
            f = m;
        else if (m < C_1P25)
            f = (m >>> 1) + C_QUARTER;
        else if (m < C_2P5)
            f = (m >>> 4) + C_0P797;
        else
            f = C_ONE;
        return (x < 0) ? -f : f;
    endfunction

`ifdef MATRIX_ACT_SIGMOID_EN
    // sigmoid(x) = (tanh(x/2) + 1) / 2; the sum is at most 2.0 and fits.
    function automatic logic signed [DATA_WIDTH-1:0] sigmoid_pw(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] t;
        t = tanh_pw(x >>> 1);
        return (t + C_ONE) >>> 1;
    endfunction
`else
    logic unused_mode;
    assign unused_mode = mode_q;
`endif

    function automatic logic signed [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] x,
                                                         input logic sel);
`ifdef MATRIX_ACT_SIGMOID_EN
        return sel ? sigmoid_pw(x) : tanh_pw(x);
`else
        return sel ? tanh_pw(x) : tanh_pw(x);
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        y_d         = y_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d      = a;
                    mode_d     = mode;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Lanes past the last element are skipped so padding never
                // touches y.
                for (int l = 0; l < LANES; l++) begin
                    if (int'(idx_q) + l < N)
                        y_d[(int'(idx_q) + l)*DATA_WIDTH +: DATA_WIDTH] =
                            act(buf_q[(int'(idx_q) + l)*DATA_WIDTH +: DATA_WIDTH], mode_q);
                end
                idx_d = idx_q + IDX_W'(LANES);
                if (int'(idx_q) + LANES >= N) begin
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            y_q         <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Captured operand buffer carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;

endmodule

// File: tb/tb_matrix_act_stream.sv
// ---------------------------------------------------------------------------
// tb_matrix_act_stream
//
// Bench for matrix_act_stream with H=W=3, LANES=4, DATA_WIDTH=16,
// FRACT_WIDTH=8. Honours MATRIX_ACT_SIGMOID_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_matrix_act_stream;

    localparam int H  = 3;
    localparam int W  = 3;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int LN = 4;
    localparam int N  = H * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [N*DW-1:0] a;
    logic          out_valid;
    logic          out_ready;
    logic [N*DW-1:0] y;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    matrix_act_stream #(
        .H(H), .W(W), .DATA_WIDTH(DW), .FRACT_WIDTH(FW), .LANES(LN)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference tanh in Q8 from the breakpoints 0.5, 1.25, 2.5 (128, 320, 640).
    function automatic int ref_tanh(input int x);
        int m;
        int f;
        m = (x < 0) ? -x : x;
        if (m > 32767) m = 32767;
        if (m < 128)      f = m;
        else if (m < 320) f = m / 2 + 64;
        else if (m < 640) f = m / 16 + 204;
        else              f = 256;
        return (x < 0) ? -f : f;
    endfunction

    function automatic logic [15:0] ref_act(input logic [15:0] raw, input logic md);
        int x;
        x = int'($signed(raw));
`ifdef MATRIX_ACT_SIGMOID_EN
        if (md) return 16'((ref_tanh(x >>> 1) + 256) / 2);
`endif
        return 16'(ref_tanh(x));
    endfunction

    function automatic logic [N*DW-1:0] ref_mat(input logic [N*DW-1:0] m, input logic md);
        logic [N*DW-1:0] r;
        r = '0;
        for (int e = 0; e < N; e++) r[e*DW +: DW] = ref_act(m[e*DW +: DW], md);
        return r;
    endfunction

    function automatic logic [15:0] rand_elem();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 1400) - 700);
            default: return 16'($urandom_range(0, 200) - 100);
        endcase
    endfunction

    function automatic logic [N*DW-1:0] rand_mat();
        logic [N*DW-1:0] m;
        for (int e = 0; e < N; e++) m[e*DW +: DW] = rand_elem();
        return m;
    endfunction

    // Entered and left at a falling edge with the DUT in IDLE.
    task automatic run_job(input logic [N*DW-1:0] mat, input logic md,
                           input bit hold_valid, input int hold_cycles);
        logic [N*DW-1:0] exp_y;
        int  cyc;
        bit  seen;
        exp_y     = ref_mat(mat, md);
        a         = mat;
        mode      = md;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        if (!hold_valid) in_valid = 1'b0;
        cyc  = 0;
        seen = 0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
            end else begin
                check($sformatf("busy_run%0d", cyc), {31'b0, busy}, 32'd1);
                check($sformatf("in_ready_run%0d", cyc), {31'b0, in_ready}, 32'd0);
                if (hold_valid) a = rand_mat();
                @(posedge clk);
                cyc++;
            end
        end
        check("out_valid_seen", {31'b0, seen}, 32'd1);
        check("run_cycles", cyc, (N + LN - 1) / LN);
        check("busy_done", {31'b0, busy}, 32'd0);
        for (int e = 0; e < N; e++)
            check($sformatf("y[%0d]", e), {16'b0, y[e*DW +: DW]}, {16'b0, exp_y[e*DW +: DW]});
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check("hold_out_valid", {31'b0, out_valid}, 32'd1);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("hold_y", {31'b0, (y == exp_y)}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_out_valid", {31'b0, out_valid}, 32'd0);
        check("idle_y_kept", {31'b0, (y == exp_y)}, 32'd1);
    endtask

    initial begin
        logic [N*DW-1:0] mat;
        bit              ov_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        a         = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_y_zero", {31'b0, (y == '0)}, 32'd1);

        // Directed tanh values, including region boundaries.
        mat = {16'h0140, 16'h0080, 16'h7FFF, 16'h8000, 16'h0300,
               16'h0200, 16'hFF40, 16'h00C0, 16'h0040};
        run_job(mat, 1'b0, 1'b0, 5);
        check("tanh_0040", {16'b0, y[0*DW +: DW]}, 32'h0040);
        check("tanh_00C0", {16'b0, y[1*DW +: DW]}, 32'h00A0);
        check("tanh_FF40", {16'b0, y[2*DW +: DW]}, 32'hFF60);
        check("tanh_0200", {16'b0, y[3*DW +: DW]}, 32'h00EC);
        check("tanh_0300", {16'b0, y[4*DW +: DW]}, 32'h0100);
        check("tanh_8000", {16'b0, y[5*DW +: DW]}, 32'hFF00);

        // Sigmoid request; without the macro it must fall back to tanh.
        mat = rand_mat();
        mat[0*DW +: DW] = 16'h0000;
        mat[1*DW +: DW] = 16'h0400;
        run_job(mat, 1'b1, 1'b0, 0);
`ifdef MATRIX_ACT_SIGMOID_EN
        check("sig_0000", {16'b0, y[0*DW +: DW]}, 32'h0080);
        check("sig_0400", {16'b0, y[1*DW +: DW]}, 32'h00F6);
`else
        check("sig_off_0000", {16'b0, y[0*DW +: DW]}, 32'h0000);
        check("sig_off_0400", {16'b0, y[1*DW +: DW]}, 32'h0100);
`endif

        // Randomised matrices and modes; one job keeps in_valid high and
        // scrambles a while running.
        for (int j = 0; j < 8; j++)
            run_job(rand_mat(), 1'($urandom_range(0, 1)), (j == 2), $urandom_range(0, 3));

        // Reset two cycles after acceptance discards the matrix.
        a        = rand_mat();
        mode     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_y_zero", {31'b0, (y == '0)}, 32'd1);
        ov_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
        end
        check("abort_no_out_valid", {31'b0, ov_seen}, 32'd0);

        run_job(rand_mat(), 1'b0, 1'b0, 1);
        run_job(rand_mat(), 1'b1, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
